// File: rtl/mem_lsu_sb.sv
// MEM stage with a non-blocking store buffer that drains to mem_ctrl in the background.
// Define LSU_STLF_EN to add store-to-load forwarding. Type codes: LB=1 LH=2 LW=3 LBU=4 LHU=5 SB=6 SH=7 SW=8.
module mem_lsu_sb #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_enable_i,
  input  logic              load_enable_i,
  input  logic              store_enable_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        load_store_type_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [4:0]        rd_addr_o,
  output logic              rd_enable_o,
  output logic              stall,
  input  logic              mem_rdy,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_ldata,
  output logic              mem_needed,
  output logic [DATA_W-1:0] mem_sdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_width,
  output logic              mem_read_write,
  output logic              mem_fw,
  output logic [DATA_W-1:0] mem_fw_data,
  output logic [4:0]        mem_fw_addr,
  output logic              sb_empty
);
  localparam logic [3:0] EXE_LB  = 4'd1;
  localparam logic [3:0] EXE_LH  = 4'd2;
  localparam logic [3:0] EXE_LW  = 4'd3;
  localparam logic [3:0] EXE_LBU = 4'd4;
  localparam logic [3:0] EXE_LHU = 4'd5;
  localparam logic [3:0] EXE_SB  = 4'd6;
  localparam logic [3:0] EXE_SH  = 4'd7;
  localparam logic [3:0] EXE_SW  = 4'd8;
  localparam int PTR_W = $clog2(SB_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_REQ  = 3'd1,
    LD_WAIT = 3'd2,
    ST_REQ  = 3'd3,
    ST_WAIT = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0] sb_addr_q  [SB_DEPTH];
  logic [2:0]        sb_width_q [SB_DEPTH];
  logic [DATA_W-1:0] sb_data_q  [SB_DEPTH];

  logic              full, pop, enq, ld_eligible, fwd_hit;
  logic [2:0]        acc_width;
  logic [DATA_W-1:0] fwd_data;

  function automatic logic [2:0] access_width(input logic [3:0] t);
    case (t)
      EXE_LB, EXE_LBU, EXE_SB: return 3'd1;
      EXE_LH, EXE_LHU, EXE_SH: return 3'd2;
      EXE_LW, EXE_SW:          return 3'd4;
      default:                 return 3'd4;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] mask_store(input logic [DATA_W-1:0] d, input logic [2:0] w);
    case (w)
      3'd1:    return {{(DATA_W-8){1'b0}}, d[7:0]};
      3'd2:    return {{(DATA_W-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] d, input logic [3:0] t);
    case (t)
      EXE_LB:  return {{(DATA_W-8){d[7]}}, d[7:0]};
      EXE_LBU: return {{(DATA_W-8){1'b0}}, d[7:0]};
      EXE_LH:  return {{(DATA_W-16){d[15]}}, d[15:0]};
      EXE_LHU: return {{(DATA_W-16){1'b0}}, d[15:0]};
      EXE_LW:  return d;
      default: return d;
    endcase
  endfunction

  assign acc_width = access_width(load_store_type_i);
  assign full      = (count_q == (PTR_W+1)'(SB_DEPTH));
  assign sb_empty  = (count_q == '0);
  assign pop       = (state_q == ST_WAIT) && mem_rdy;
  // A full buffer still accepts a store in the cycle its head retires.
  assign enq       = store_enable_i && (!full || pop);

`ifdef LSU_STLF_EN
  logic             same_word;
  logic [PTR_W-1:0] fwd_idx;

  // Walk oldest to youngest so the last same-word entry decides hit or wait.
  always_comb begin
    same_word = 1'b0;
    fwd_hit   = 1'b0;
    fwd_data  = '0;
    fwd_idx   = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) &&
          (sb_addr_q[fwd_idx][ADDR_W-1:2] == mem_addr_i[ADDR_W-1:2])) begin
        same_word = 1'b1;
        fwd_hit   = (sb_addr_q[fwd_idx] == mem_addr_i) && (sb_width_q[fwd_idx] >= acc_width);
        fwd_data  = sb_data_q[fwd_idx];
      end
    end
    fwd_hit = fwd_hit && load_enable_i;
  end

  assign ld_eligible = load_enable_i && !same_word && (state_q == IDLE);
`else
  assign fwd_hit     = 1'b0;
  assign fwd_data    = '0;
  assign ld_eligible = load_enable_i && sb_empty && (state_q == IDLE);
`endif

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + 1'b1;
    if (pop) head_d = head_q + 1'b1;
    case ({enq, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      sb_addr_q[tail_q]  <= mem_addr_i;
      sb_width_q[tail_q] <= acc_width;
      sb_data_q[tail_q]  <= mask_store(rd_data_i, acc_width);
    end
  end

  // Drain starts the cycle after a store lands, even into an empty buffer.
  always_comb begin
    state_d        = state_q;
    stall          = 1'b0;
    rd_data_o      = rd_data_i;
    mem_needed     = 1'b0;
    mem_sdata      = '0;
    mem_addr       = '0;
    mem_width      = '0;
    mem_read_write = 1'b0;
    case (state_q)
      IDLE:    if (ld_eligible) state_d = LD_REQ;
               else if (!sb_empty || enq) state_d = ST_REQ;
      LD_REQ:  if (!mem_busy) state_d = LD_WAIT;
      LD_WAIT: if (mem_rdy) state_d = IDLE;
      ST_REQ:  if (!mem_busy) state_d = ST_WAIT;
      ST_WAIT: if (mem_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q == LD_REQ || state_q == LD_WAIT) begin
      mem_needed     = (state_q == LD_REQ);
      mem_addr       = mem_addr_i;
      mem_width      = acc_width;
      mem_read_write = 1'b1;
    end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
      mem_needed = (state_q == ST_REQ);
      mem_addr   = sb_addr_q[head_q];
      mem_width  = sb_width_q[head_q];
      mem_sdata  = sb_data_q[head_q];
    end
    if (load_enable_i) begin
      rd_data_o = extend_load(fwd_hit ? fwd_data : mem_ldata, load_store_type_i);
      stall     = !fwd_hit && !((state_q == LD_WAIT) && mem_rdy);
    end else if (store_enable_i) begin
      stall = full && !pop;
    end
    if (rst) begin
      stall          = 1'b0;
      rd_data_o      = '0;
      mem_needed     = 1'b0;
      mem_sdata      = '0;
      mem_addr       = '0;
      mem_width      = '0;
      mem_read_write = 1'b0;
    end
  end

  assign rd_addr_o   = rst ? 5'd0 : rd_addr_i;
  assign rd_enable_o = rst ? 1'b0 : rd_enable_i;
  assign mem_fw      = !rst;
  assign mem_fw_addr = rst ? 5'd0 : rd_addr_i;
  assign mem_fw_data = rst ? '0 : (load_enable_i ? rd_data_o : rd_data_i);
endmodule

// File: tb/tb_mem_lsu_sb.sv
// Directed bench for mem_lsu_sb with a request/load-result scoreboard and an optional auto mem_rdy responder.
module tb_mem_lsu_sb;
  localparam logic [3:0] T_LB = 4'd1, T_LH = 4'd2, T_LW = 4'd3, T_LBU = 4'd4;
  localparam logic [3:0] T_LHU = 4'd5, T_SB = 4'd6, T_SW = 4'd8;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  width;
    logic        rw;
    logic [31:0] sdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_data_i, mem_addr_i, rd_data_o, mem_ldata, mem_sdata, mem_addr, mem_fw_data;
  logic [4:0]  rd_addr_i, rd_addr_o, mem_fw_addr;
  logic        rd_enable_i, load_enable_i, store_enable_i, rd_enable_o, stall;
  logic [3:0]  load_store_type_i;
  logic        mem_rdy, mem_busy, mem_needed, mem_read_write, mem_fw, sb_empty;
  logic [2:0]  mem_width;

  int          vectors = 0;
  int          miscompares = 0;
  bit          auto_rdy = 1'b0;
  bit          acc = 1'b0;
  logic [31:0] resp_data = '0;
  req_t        exp_req[$];
  logic [31:0] exp_ld[$];
  logic [4:0]  cur_rd = '0;
  int          n;

  logic [3:0]  t3_ty  [5] = '{T_LB, T_LBU, T_LH, T_LHU, T_LW};
  logic [31:0] t3_mem [5] = '{32'h0000_00F0, 32'h1234_80F0, 32'h0000_8001, 32'hABCD_8001, 32'h8000_0001};
  logic [31:0] t3_exp [5] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8001, 32'h0000_8001, 32'h8000_0001};
  logic [2:0]  t3_w   [5] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd4};

  mem_lsu_sb dut (
    .clk(clk), .rst(rst),
    .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .rd_enable_i(rd_enable_i),
    .load_enable_i(load_enable_i), .store_enable_i(store_enable_i),
    .mem_addr_i(mem_addr_i), .load_store_type_i(load_store_type_i),
    .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .rd_enable_o(rd_enable_o), .stall(stall),
    .mem_rdy(mem_rdy), .mem_busy(mem_busy), .mem_ldata(mem_ldata),
    .mem_needed(mem_needed), .mem_sdata(mem_sdata), .mem_addr(mem_addr), .mem_width(mem_width),
    .mem_read_write(mem_read_write), .mem_fw(mem_fw), .mem_fw_data(mem_fw_data),
    .mem_fw_addr(mem_fw_addr), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] a, input logic [2:0] w, input logic rw, input logic [31:0] d);
    req_t r;
    r.addr = a; r.width = w; r.rw = rw; r.sdata = d;
    exp_req.push_back(r);
  endtask

  task automatic drive(input logic ld, input logic st, input logic [3:0] ty, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd, input logic en);
    load_enable_i = ld; store_enable_i = st; load_store_type_i = ty;
    mem_addr_i = a; rd_data_i = d; rd_addr_i = rd; rd_enable_i = en; cur_rd = rd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  task automatic sb_mon();
    req_t r;
    logic [31:0] e;
    if (!rst) begin
      if (mem_needed && !mem_busy) begin
        if (exp_req.size() == 0) chk("req_unexpected", {31'd0, mem_needed}, 32'd0);
        else begin
          r = exp_req.pop_front();
          chk("req_addr", mem_addr, r.addr);
          chk("req_width", {29'd0, mem_width}, {29'd0, r.width});
          chk("req_rw", {31'd0, mem_read_write}, {31'd0, r.rw});
          if (!r.rw) chk("req_sdata", mem_sdata, r.sdata);
        end
      end
      if (load_enable_i && !stall) begin
        if (exp_ld.size() == 0) chk("ld_unexpected", {31'd0, stall}, 32'd1);
        else begin
          e = exp_ld.pop_front();
          chk("ld_data", rd_data_o, e);
          chk("ld_fw_data", mem_fw_data, e);
          chk("ld_fw_addr", {27'd0, mem_fw_addr}, {27'd0, cur_rd});
        end
      end
    end
    if (mem_rdy) acc = 1'b0;
    if (mem_needed && !mem_busy) acc = 1'b1;
  endtask

  task automatic fall();
    @(negedge clk);
    sb_mon();
  endtask

  task automatic rise();
    @(posedge clk);
    #1;
    if (auto_rdy && acc) begin
      mem_rdy = 1'b1; mem_ldata = resp_data;
    end else begin
      mem_rdy = 1'b0;
    end
  endtask

  task automatic wait_load(input int budget, output int cyc);
    cyc = 0;
    fall();
    while (stall && cyc < budget) begin
      rise(); fall(); cyc++;
    end
    chk("ld_timeout", {31'd0, stall}, 32'd0);
  endtask

  task automatic run_until_empty(input int budget);
    int k = 0;
    fall();
    while (!sb_empty && k < budget) begin
      rise(); fall(); k++;
    end
    chk("drain_empty", {31'd0, sb_empty}, 32'd1);
    rise();
  endtask

  initial begin
    rst = 1'b1; mem_rdy = 1'b0; mem_busy = 1'b0; mem_ldata = '0;
    drive(1'b1, 1'b0, T_LW, 32'h40, 32'hAAAA_5555, 5'd3, 1'b1);
    // Reset values, with live inputs that must not leak through.
    fall();
    chk("rst_rd_data", rd_data_o, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_needed", {31'd0, mem_needed}, 32'd0);
    chk("rst_mem_fw", {31'd0, mem_fw}, 32'd0);
    chk("rst_rd_en", {31'd0, rd_enable_o}, 32'd0);
    chk("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
    rise();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'h0000_1234, 5'd5, 1'b1);
    fall();
    chk("alu_rd_data", rd_data_o, 32'h0000_1234);
    chk("alu_rd_en", {31'd0, rd_enable_o}, 32'd1);
    chk("alu_fw", {31'd0, mem_fw}, 32'd1);
    chk("alu_fw_data", mem_fw_data, 32'h0000_1234);
    chk("alu_fw_addr", {27'd0, mem_fw_addr}, 32'd5);
    rise();

    // SW 0xDEADBEEF @0x100, bus busy for one cycle of ST_REQ
    drive(1'b0, 1'b1, T_SW, 32'h100, 32'hDEAD_BEEF, 5'd0, 1'b0);
    push_req(32'h100, 3'd4, 1'b0, 32'hDEAD_BEEF);
    mem_busy = 1'b1;
    fall();
    chk("t1_stall", {31'd0, stall}, 32'd0);
    chk("t1_idle_req", {31'd0, mem_needed}, 32'd0);
    rise();
    idle();
    fall();
    chk("t1_req", {31'd0, mem_needed}, 32'd1);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_width", {29'd0, mem_width}, 32'd4);
    chk("t1_rw", {31'd0, mem_read_write}, 32'd0);
    rise();
    mem_busy = 1'b0;
    fall();
    chk("t1_req_held", {31'd0, mem_needed}, 32'd1);
    rise();
    fall();
    chk("t1_wait_req", {31'd0, mem_needed}, 32'd0);
    rise();
    mem_rdy = 1'b1;
    fall();
    chk("t1_rdy_not_empty", {31'd0, sb_empty}, 32'd0);
    rise();
    fall();
    chk("t1_empty", {31'd0, sb_empty}, 32'd1);
    rise();

    // Five SBs into a 4-deep buffer, memory not answering
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, T_SB, 32'h400 + 32'(i), 32'hFFFF_FF00 | 32'((i + 1) * 17), 5'd0, 1'b0);
      push_req(32'h400 + 32'(i), 3'd1, 1'b0, 32'((i + 1) * 17));
      fall();
      chk("t2_stall", {31'd0, stall}, (i == 4) ? 32'd1 : 32'd0);
      rise();
    end
    fall();
    chk("t2_stall_hold", {31'd0, stall}, 32'd1);
    rise();
    mem_rdy = 1'b1;
    fall();
    chk("t2_pop_enq", {31'd0, stall}, 32'd0);
    rise();
    drive(1'b0, 1'b1, T_SB, 32'h405, 32'h0000_0066, 5'd0, 1'b0);
    push_req(32'h405, 3'd1, 1'b0, 32'h66);
    fall();
    chk("t2_still_full", {31'd0, stall}, 32'd1);
    rise();
    fall();
    chk("t2_still_full2", {31'd0, stall}, 32'd1);
    rise();
    mem_rdy = 1'b1;
    fall();
    chk("t2_pop2", {31'd0, stall}, 32'd0);
    rise();
    idle();
    auto_rdy = 1'b1;
    run_until_empty(40);
    chk("t2_req_left", 32'(exp_req.size()), 32'd0);

    // Load extension through the bus
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, t3_ty[i], 32'h200, 32'd0, 5'd7, 1'b1);
      resp_data = t3_mem[i];
      push_req(32'h200, t3_w[i], 1'b1, 32'd0);
      exp_ld.push_back(t3_exp[i]);
      wait_load(20, n);
      chk("t3_latency", 32'(n), 32'd2);
      chk("t3_rdy_cycle", {31'd0, mem_rdy}, 32'd1);
      rise();
    end
    idle();

    // SW then LH to the same address
    drive(1'b0, 1'b1, T_SW, 32'h300, 32'h1234_5678, 5'd0, 1'b0);
    push_req(32'h300, 3'd4, 1'b0, 32'h1234_5678);
    fall();
    rise();
    drive(1'b1, 1'b0, T_LH, 32'h300, 32'd0, 5'd9, 1'b1);
    exp_ld.push_back(32'h0000_5678);
`ifdef LSU_STLF_EN
    fall();
    chk("t4_fwd_stall", {31'd0, stall}, 32'd0);
    chk("t4_no_read", {31'd0, mem_read_write}, 32'd0);
    rise();
    idle();
`else
    resp_data = 32'h0000_5678;
    push_req(32'h300, 3'd2, 1'b1, 32'd0);
    wait_load(20, n);
    chk("t4_latency", 32'(n), 32'd4);
    chk("t4_empty_at_load", {31'd0, sb_empty}, 32'd1);
    rise();
    idle();
`endif
    run_until_empty(20);

    // SB to the same word behind a SW blocks the LW until both drain
    drive(1'b0, 1'b1, T_SW, 32'h300, 32'hCAFE_F00D, 5'd0, 1'b0);
    push_req(32'h300, 3'd4, 1'b0, 32'hCAFE_F00D);
    fall();
    rise();
    drive(1'b0, 1'b1, T_SB, 32'h301, 32'h7777_77AB, 5'd0, 1'b0);
    push_req(32'h301, 3'd1, 1'b0, 32'h0000_00AB);
    fall();
    rise();
    drive(1'b1, 1'b0, T_LW, 32'h300, 32'd0, 5'd11, 1'b1);
    resp_data = 32'hA5A5_A5A5;
    push_req(32'h300, 3'd4, 1'b1, 32'd0);
    exp_ld.push_back(32'hA5A5_A5A5);
    wait_load(30, n);
    chk("t5_latency", 32'(n), 32'd6);
    chk("t5_empty_at_load", {31'd0, sb_empty}, 32'd1);
    chk("t5_bus_read", {31'd0, mem_read_write}, 32'd1);
    rise();

    // Reset while a load waits for mem_rdy
    auto_rdy = 1'b0;
    drive(1'b1, 1'b0, T_LW, 32'h700, 32'h0000_00EE, 5'd12, 1'b1);
    push_req(32'h700, 3'd4, 1'b1, 32'd0);
    fall();
    rise();
    fall();
    rise();
    rst = 1'b1;
    #1;
    chk("t6_stall", {31'd0, stall}, 32'd0);
    chk("t6_rd_data", rd_data_o, 32'd0);
    chk("t6_rw", {31'd0, mem_read_write}, 32'd0);
    chk("t6_addr", mem_addr, 32'd0);
    chk("t6_fw", {31'd0, mem_fw}, 32'd0);
    chk("t6_sb_empty", {31'd0, sb_empty}, 32'd1);
    fall();
    acc = 1'b0;
    rise();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'h0000_0055, 5'd1, 1'b1);
    mem_rdy = 1'b1; mem_ldata = 32'h0000_FFFF;
    fall();
    chk("t6_late_rdy_data", rd_data_o, 32'h0000_0055);
    chk("t6_late_rdy_stall", {31'd0, stall}, 32'd0);
    chk("t6_late_rdy_req", {31'd0, mem_needed}, 32'd0);
    rise();
    fall();
    chk("t6_idle_req", {31'd0, mem_needed}, 32'd0);
    chk("t6_idle_empty", {31'd0, sb_empty}, 32'd1);
    rise();
    chk("end_req_left", 32'(exp_req.size()), 32'd0);
    chk("end_ld_left", 32'(exp_ld.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
